// File: rtl/transmitter_serializer_if.sv
// Frame-load handshake and serial mux-drive signals between the parity
// generator, the serializer and the output mux.
interface transmitter_serializer_if #(
  parameter int LM = 16,
  parameter int LP = 16
);
  logic          load_valid;
  logic          load_ready;
  logic [LM-1:0] msg_in;
  logic [LP-1:0] par_in;
  logic          tx_en;
  logic          msg_bit;
  logic          par_bit;
  logic          sel;
  logic          bit_valid;
  logic          frame_start;
  logic          frame_end;

  modport master (
    output load_valid, msg_in, par_in, tx_en,
    input  load_ready, msg_bit, par_bit, sel, bit_valid, frame_start, frame_end
  );

  modport slave (
    input  load_valid, msg_in, par_in, tx_en,
    output load_ready, msg_bit, par_bit, sel, bit_valid, frame_start, frame_end
  );
endinterface

// File: rtl/transmitter_serializer.sv
// Serializes one {message, parity} frame MSB first: message segment on the
// mux in1 lane (sel=1), then parity segment on the in2 lane (sel=0).
module transmitter_serializer #(
  parameter int LM = 16,
  parameter int LP = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  transmitter_serializer_if.slave bus
);

  localparam int MAXL = (LM > LP) ? LM : LP;
  localparam int CW   = ($clog2(MAXL) < 1) ? 1 : $clog2(MAXL);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MSG  = 2'd1,
    S_PAR  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LM-1:0] msg_sr_q, msg_sr_d;
  logic [LP-1:0] par_sr_q, par_sr_d;
  logic [CW-1:0] count_q, count_d;

  logic load_ready_q, load_ready_d;
  logic sel_q, sel_d;
  logic msg_bit_q, msg_bit_d;
  logic par_bit_q, par_bit_d;
  logic bit_valid_q, bit_valid_d;
  logic frame_start_q, frame_start_d;
  logic frame_end_q, frame_end_d;

  // Next-state, shift-register and bit-counter update.
  always_comb begin
    state_d  = state_q;
    msg_sr_d = msg_sr_q;
    par_sr_d = par_sr_q;
    count_d  = count_q;
    case (state_q)
      S_IDLE: begin
        if (bus.load_valid) begin
          msg_sr_d = bus.msg_in;
          par_sr_d = bus.par_in;
          count_d  = {CW{1'b0}};
          state_d  = S_MSG;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MSG: begin
        if (bus.tx_en) begin
          msg_sr_d = {msg_sr_q[LM-2:0], 1'b0};
          if (count_q == CW'(LM-1)) begin
            count_d = {CW{1'b0}};
            state_d = S_PAR;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = S_MSG;
        end
      end
      S_PAR: begin
        if (bus.tx_en) begin
          par_sr_d = {par_sr_q[LP-2:0], 1'b0};
          // Last parity bit leaving: a waiting frame is taken with no idle gap.
          if (count_q == CW'(LP-1)) begin
            count_d = {CW{1'b0}};
            if (bus.load_valid) begin
              msg_sr_d = bus.msg_in;
              par_sr_d = bus.par_in;
              state_d  = S_MSG;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          state_d = S_PAR;
        end
      end
      default: begin
        state_d  = S_IDLE;
        msg_sr_d = {LM{1'b0}};
        par_sr_d = {LP{1'b0}};
        count_d  = {CW{1'b0}};
      end
    endcase
  end

  // Output values for the cycle after this edge, derived from the next state
  // so that every output is a flop and a stall holds them unchanged.
  always_comb begin
    load_ready_d  = 1'b0;
    sel_d         = 1'b1;
    msg_bit_d     = 1'b0;
    par_bit_d     = 1'b0;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_end_d   = 1'b0;
    case (state_d)
      S_IDLE: begin
        load_ready_d = 1'b1;
      end
      S_MSG: begin
        bit_valid_d   = 1'b1;
        msg_bit_d     = msg_sr_d[LM-1];
        frame_start_d = (count_d == {CW{1'b0}});
      end
      S_PAR: begin
        sel_d        = 1'b0;
        bit_valid_d  = 1'b1;
        par_bit_d    = par_sr_d[LP-1];
        frame_end_d  = (count_d == CW'(LP-1));
        load_ready_d = (count_d == CW'(LP-1));
      end
      default: begin
        load_ready_d = 1'b1;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      msg_sr_q      <= {LM{1'b0}};
      par_sr_q      <= {LP{1'b0}};
      count_q       <= {CW{1'b0}};
      load_ready_q  <= 1'b1;
      sel_q         <= 1'b1;
      msg_bit_q     <= 1'b0;
      par_bit_q     <= 1'b0;
      bit_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      msg_sr_q      <= msg_sr_d;
      par_sr_q      <= par_sr_d;
      count_q       <= count_d;
      load_ready_q  <= load_ready_d;
      sel_q         <= sel_d;
      msg_bit_q     <= msg_bit_d;
      par_bit_q     <= par_bit_d;
      bit_valid_q   <= bit_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign bus.load_ready  = load_ready_q;
  assign bus.sel         = sel_q;
  assign bus.msg_bit     = msg_bit_q;
  assign bus.par_bit     = par_bit_q;
  assign bus.bit_valid   = bit_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;

endmodule

// File: tb/tb_transmitter_serializer.sv
// Bench for transmitter_serializer: directed frame table, corner sequences and
// random traffic against a frame-position reference model.
module tb_transmitter_serializer;
  localparam int LM = 16;
  localparam int LP = 16;
  localparam int FL = LM + LP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  transmitter_serializer_if #(.LM(LM), .LP(LP)) bus ();
  transmitter_serializer #(.LM(LM), .LP(LP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // Packed output order: {load_ready, sel, msg_bit, par_bit, bit_valid, frame_start, frame_end}
  localparam logic [6:0] IDLE_OUT = 7'b1100000;

  typedef struct {
    logic          lv;
    logic [LM-1:0] msg;
    logic [LP-1:0] par;
    logic          tx;
    logic [6:0]    exp;
  } vec_t;

  vec_t tbl[33];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: a frame is a sequence of FL bit positions.
  bit            m_active = 1'b0;
  int            m_pos = 0;
  logic [LM-1:0] m_msg = '0;
  logic [LP-1:0] m_par = '0;

  function automatic logic [6:0] model_out();
    logic last;
    if (!m_active) return IDLE_OUT;
    last = (m_pos == FL - 1);
    if (m_pos < LM)
      return {1'b0, 1'b1, m_msg[LM-1-m_pos], 1'b0, 1'b1, (m_pos == 0), 1'b0};
    return {last, 1'b0, 1'b0, m_par[LP-1-(m_pos-LM)], 1'b1, 1'b0, last};
  endfunction

  function automatic logic [6:0] dut_out();
    return {bus.load_ready, bus.sel, bus.msg_bit, bus.par_bit,
            bus.bit_valid, bus.frame_start, bus.frame_end};
  endfunction

  task automatic model_load();
    m_active = 1'b1;
    m_pos    = 0;
    m_msg    = bus.msg_in;
    m_par    = bus.par_in;
  endtask

  task automatic model_edge();
    if (!m_active) begin
      if (bus.load_valid) model_load();
    end else if (bus.tx_en) begin
      if (m_pos == FL - 1) begin
        if (bus.load_valid) model_load();
        else m_active = 1'b0;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step(input string name);
    @(posedge clk);
    model_edge();
    #1;
    check(name, 32'(dut_out()), 32'(model_out()));
  endtask

  task automatic drive(input logic lv, input logic [LM-1:0] msg, input logic [LP-1:0] par, input logic tx);
    bus.load_valid = lv;
    bus.msg_in     = msg;
    bus.par_in     = par;
    bus.tx_en      = tx;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, 1'b1);
    repeat (FL + 4) step("drain");
  endtask

  initial begin
    logic [15:0] mseq;
    logic [15:0] pseq;
    logic [6:0]  held;
    int          vcnt;
    int          guard;

    mseq = 16'b1010_0101_1100_0011;
    pseq = 16'b0000_1111_0000_1111;
    tbl[0] = '{1'b1, 16'hA5C3, 16'h0F0F, 1'b1, 7'b0110110};
    for (int i = 1; i < FL; i++) begin
      if (i < LM)
        tbl[i] = '{1'b0, 16'h0000, 16'h0000, 1'b1, {1'b0, 1'b1, mseq[15-i], 1'b0, 1'b1, 1'b0, 1'b0}};
      else
        tbl[i] = '{1'b0, 16'h0000, 16'h0000, 1'b1,
                   {(i == FL-1), 1'b0, 1'b0, pseq[15-(i-LM)], 1'b1, 1'b0, (i == FL-1)}};
    end
    tbl[FL] = '{1'b0, 16'h0000, 16'h0000, 1'b1, IDLE_OUT};

    drive(1'b0, '0, '0, 1'b0);
    #12;
    check("reset_state", 32'(dut_out()), 32'(IDLE_OUT));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single frame from the table.
    for (int i = 0; i <= FL; i++) begin
      drive(tbl[i].lv, tbl[i].msg, tbl[i].par, tbl[i].tx);
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("tbl[%0d]", i), 32'(dut_out()), 32'(tbl[i].exp));
    end

    // Back-to-back frames with load_valid held high.
    drive(1'b1, 16'h1234, 16'hABCD, 1'b1);
    step("b2b_accept");
    drive(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    for (int i = 1; i < FL; i++) step("b2b_f1");
    check("b2b_f1_end", 32'(bus.frame_end), 32'd1);
    step("b2b_f2");
    check("b2b_f2_first", 32'(dut_out()), 32'(7'b0110110));
    drain();

    // Stall three cycles on message bit 5; frame must span 35 valid cycles.
    drive(1'b1, 16'hA5C3, 16'h0F0F, 1'b1);
    step("stall_accept");
    bus.load_valid = 1'b0;
    vcnt = 1;
    for (int i = 1; i <= 5; i++) begin
      step("stall_pre");
      vcnt++;
    end
    held = dut_out();
    bus.tx_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step("stall_model");
      check("stall_hold", 32'(dut_out()), 32'(held));
      vcnt++;
    end
    bus.tx_en = 1'b1;
    guard = 0;
    while (bus.bit_valid === 1'b1 && guard < 100) begin
      step("stall_post");
      if (bus.bit_valid === 1'b1) vcnt++;
      guard++;
    end
    check("stall_len", 32'(vcnt), 32'd35);
    drain();

    // Asynchronous reset while on parity bit 4.
    drive(1'b1, 16'h5A5A, 16'hC3C3, 1'b1);
    step("rst_accept");
    bus.load_valid = 1'b0;
    for (int i = 1; i <= LM + 4; i++) step("rst_run");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'(dut_out()), 32'(IDLE_OUT));
    m_active = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h8001, 16'h7FFE, 1'b1);
    step("rst_reload");
    check("rst_reload_start", 32'(dut_out()), 32'(7'b0110110));
    bus.load_valid = 1'b0;
    drain();

    // load_valid pulsed mid-message must be ignored.
    drive(1'b1, 16'h3C5A, 16'h9669, 1'b1);
    step("ign_accept");
    bus.load_valid = 1'b0;
    for (int i = 1; i <= 8; i++) step("ign_pre");
    check("ign_ready", 32'(bus.load_ready), 32'd0);
    drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    step("ign_pulse");
    check("ign_ready_after", 32'(bus.load_ready), 32'd0);
    bus.load_valid = 1'b0;
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      drive(($urandom_range(0, 1) == 1), LM'($urandom), LP'($urandom), ($urandom_range(0, 3) != 0));
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
